// File: rtl/pulse_pacer.sv
// Re-emits bursty single-cycle events as pulses spaced GAP cycles apart, backlog held in a saturating counter.
// Latency: event to pulse_out is 1 cycle when idle; no backpressure: events past a full backlog are dropped and flagged.
module pulse_pacer #(
  parameter int CNT_W = 8,
  parameter int GAP   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             event_in,
  input  logic             flush,
  input  logic             ovf_clr,
  output logic             pulse_out,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             overflow
);

  typedef enum logic {
    IDLE,
    GAP_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] PEND_MAX = '1;
  localparam logic [7:0]       GAP_LOAD = 8'(GAP - 1);

  state_t             state_q, state_d;
  logic [7:0]         gap_q, gap_d;
  logic [CNT_W-1:0]   pending_q, pending_d;
  logic               pulse_out_q, pulse_out_d;
  logic               overflow_q, overflow_d;
  logic               issue;
  logic               ovf_set;

  always_comb begin
    issue       = (state_q == IDLE) && !flush && ((pending_q != '0) || event_in);
    // Saturation drop only counts when the event was not already discarded by flush.
    ovf_set     = !flush && event_in && !issue && (pending_q == PEND_MAX);

    state_d     = state_q;
    gap_d       = gap_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d = GAP_WAIT;
          gap_d   = GAP_LOAD;
        end
      end
      GAP_WAIT: begin
        // Leaving when the count reaches 1 puts the next decision exactly GAP cycles after the last.
        if (gap_q <= 8'd1) begin
          state_d = IDLE;
          gap_d   = 8'd0;
        end else begin
          gap_d   = gap_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gap_d   = 8'd0;
      end
    endcase

    pending_d = pending_q;
    if (flush) begin
      pending_d = '0;
    end else if (event_in && !issue) begin
      if (pending_q != PEND_MAX) pending_d = pending_q + 1'b1;
    end else if (!event_in && issue) begin
      pending_d = pending_q - 1'b1;
    end

    pulse_out_d = issue;
    overflow_d  = ovf_set | (overflow_q & ~ovf_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gap_q       <= 8'd0;
      pending_q   <= '0;
      pulse_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      pending_q   <= pending_d;
      pulse_out_q <= pulse_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign pulse_out = pulse_out_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;
  assign busy      = (pending_q != '0) || (state_q != IDLE);

endmodule
